// File: rtl/tmnt_video_pkg.sv
// tmnt_video_pkg: shared raster timing defaults, colour-code width, layer ids and transparency test
package tmnt_video_pkg;
    localparam int H_TOTAL    = 384;
    localparam int H_ACTIVE   = 320;
    localparam int H_SYNC_ST  = 336;
    localparam int H_SYNC_LEN = 32;
    localparam int V_TOTAL    = 264;
    localparam int V_ACTIVE   = 224;
    localparam int V_SYNC_ST  = 240;
    localparam int V_SYNC_LEN = 8;
    localparam int LAYER_LAT  = 1;
    localparam int CD_W       = 10;
    localparam logic [CD_W-1:0] BACKDROP = 10'h000;

    typedef enum logic [1:0] {L_FIX, L_A, L_OBJ, L_B} layer_e;

    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
        logic vbl;
    } timing_t;

    function automatic logic transparent(input logic [CD_W-1:0] c);
        return c[3:0] == 4'h0;
    endfunction
endpackage

// File: rtl/tmnt_video_timing.sv
// tmnt_video_timing: raster counters, raw sync/blank flags and the delay line aligning them to output pixels
module tmnt_video_timing
    import tmnt_video_pkg::*;
#(
    parameter int H_TOTAL    = tmnt_video_pkg::H_TOTAL,
    parameter int H_ACTIVE   = tmnt_video_pkg::H_ACTIVE,
    parameter int H_SYNC_ST  = tmnt_video_pkg::H_SYNC_ST,
    parameter int H_SYNC_LEN = tmnt_video_pkg::H_SYNC_LEN,
    parameter int V_TOTAL    = tmnt_video_pkg::V_TOTAL,
    parameter int V_ACTIVE   = tmnt_video_pkg::V_ACTIVE,
    parameter int V_SYNC_ST  = tmnt_video_pkg::V_SYNC_ST,
    parameter int V_SYNC_LEN = tmnt_video_pkg::V_SYNC_LEN,
    parameter int LAYER_LAT  = tmnt_video_pkg::LAYER_LAT
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [8:0] hcnt,
    output logic [8:0] vcnt,
    output logic       pre_vis,
    output timing_t    tim
);
    localparam int DL = LAYER_LAT + 2;

    logic [8:0] h_q, h_d, v_q, v_d;
    timing_t raw;
    timing_t [DL-1:0] dl_q, dl_d;

    always_comb begin
        h_d = (h_q == 9'(H_TOTAL - 1)) ? 9'd0 : h_q + 9'd1;
        v_d = (h_q != 9'(H_TOTAL - 1)) ? v_q : (v_q == 9'(V_TOTAL - 1)) ? 9'd0 : v_q + 9'd1;
        raw.vis = (h_q < 9'(H_ACTIVE)) && (v_q < 9'(V_ACTIVE));
        raw.hs = (h_q >= 9'(H_SYNC_ST)) && (h_q < 9'(H_SYNC_ST + H_SYNC_LEN));
        raw.vs = (v_q >= 9'(V_SYNC_ST)) && (v_q < 9'(V_SYNC_ST + V_SYNC_LEN));
        raw.vbl = (h_q == 9'd0) && (v_q == 9'(V_ACTIVE));
        dl_d = {dl_q[DL-2:0], raw};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
            dl_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
            dl_q <= dl_d;
        end
    end

    // pre_vis lines up with the mixer's second stage, tim with its registered outputs
    assign hcnt = h_q;
    assign vcnt = v_q;
    assign pre_vis = dl_q[DL-2].vis;
    assign tim = dl_q[DL-1];
endmodule

// File: rtl/tmnt_color_mixer.sv
// tmnt_color_mixer: layer priority/shadow resolver with raster timing; TMNT_LAYER_MASK_EN adds LAYER_MASK
module tmnt_color_mixer
    import tmnt_video_pkg::*;
#(
    parameter int H_TOTAL    = tmnt_video_pkg::H_TOTAL,
    parameter int H_ACTIVE   = tmnt_video_pkg::H_ACTIVE,
    parameter int H_SYNC_ST  = tmnt_video_pkg::H_SYNC_ST,
    parameter int H_SYNC_LEN = tmnt_video_pkg::H_SYNC_LEN,
    parameter int V_TOTAL    = tmnt_video_pkg::V_TOTAL,
    parameter int V_ACTIVE   = tmnt_video_pkg::V_ACTIVE,
    parameter int V_SYNC_ST  = tmnt_video_pkg::V_SYNC_ST,
    parameter int V_SYNC_LEN = tmnt_video_pkg::V_SYNC_LEN,
    parameter int LAYER_LAT  = tmnt_video_pkg::LAYER_LAT
) (
    input  logic            V6M,
    input  logic            NRESET,
    input  logic            PRIOR,
    input  logic [CD_W-1:0] FIX_CD,
    input  logic [CD_W-1:0] A_CD,
    input  logic [CD_W-1:0] B_CD,
    input  logic [CD_W-1:0] OBJ_CD,
    input  logic            OBJ_SHD,
`ifdef TMNT_LAYER_MASK_EN
    input  logic [3:0]      LAYER_MASK,
`endif
    output logic [8:0]      HCNT,
    output logic [8:0]      VCNT,
    output logic            NHSYNC,
    output logic            NVSYNC,
    output logic            VBL_IRQ,
    output logic [CD_W-1:0] CD,
    output logic            SHADOW,
    output logic            NCBLK
);
    logic pre_vis;
    timing_t tim;
    logic [3:0] msk;
    logic [CD_W-1:0] fix_q, fix_d, a_q, a_d, b_q, b_d, obj_q, obj_d, cd_q, cd_d, win;
    logic shd_q, shd_d, prior_q, prior_d, shadow_q, shadow_d;
    logic f_op, a_op, b_op, o_op, obj_col;

    tmnt_video_timing #(
        .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE), .H_SYNC_ST(H_SYNC_ST), .H_SYNC_LEN(H_SYNC_LEN),
        .V_TOTAL(V_TOTAL), .V_ACTIVE(V_ACTIVE), .V_SYNC_ST(V_SYNC_ST), .V_SYNC_LEN(V_SYNC_LEN),
        .LAYER_LAT(LAYER_LAT)
    ) u_timing (
        .clk(V6M), .rst_n(NRESET), .hcnt(HCNT), .vcnt(VCNT), .pre_vis(pre_vis), .tim(tim)
    );

    always_comb begin
`ifdef TMNT_LAYER_MASK_EN
        msk = LAYER_MASK;
`else
        msk = 4'h0;
`endif
        fix_d = msk[0] ? '0 : FIX_CD;
        a_d = msk[1] ? '0 : A_CD;
        b_d = msk[2] ? '0 : B_CD;
        obj_d = msk[3] ? '0 : OBJ_CD;
        shd_d = OBJ_SHD & ~msk[3];
        prior_d = PRIOR;
        f_op = !transparent(fix_q);
        a_op = !transparent(a_q);
        b_op = !transparent(b_q);
        o_op = !transparent(obj_q);
        obj_col = o_op & ~shd_q;
        win = f_op ? fix_q
            : prior_q ? (a_op ? a_q : obj_col ? obj_q : b_op ? b_q : BACKDROP)
            : (obj_col ? obj_q : a_op ? a_q : b_op ? b_q : BACKDROP);
        cd_d = pre_vis ? win : '0;
        // a shadow darkens whatever wins from below the sprite's slot, never FIX (nor A when PRIOR=1)
        shadow_d = pre_vis & o_op & shd_q & ~f_op & ~(prior_q & a_op);
    end

    always_ff @(posedge V6M or negedge NRESET) begin
        if (!NRESET) begin
            fix_q <= '0;
            a_q <= '0;
            b_q <= '0;
            obj_q <= '0;
            shd_q <= 1'b0;
            prior_q <= 1'b0;
            cd_q <= '0;
            shadow_q <= 1'b0;
        end else begin
            fix_q <= fix_d;
            a_q <= a_d;
            b_q <= b_d;
            obj_q <= obj_d;
            shd_q <= shd_d;
            prior_q <= prior_d;
            cd_q <= cd_d;
            shadow_q <= shadow_d;
        end
    end

    assign CD = cd_q;
    assign SHADOW = shadow_q;
    assign NCBLK = tim.vis;
    assign NHSYNC = ~tim.hs;
    assign NVSYNC = ~tim.vs;
    assign VBL_IRQ = tim.vbl;
endmodule

// File: tb/tb_tmnt_color_mixer.sv
// tb_tmnt_color_mixer: scoreboard bench on a vertically shortened raster (horizontal timing at defaults)
module tb_tmnt_color_mixer;
    localparam int HT = 384, HA = 320, HSS = 336, HSL = 32;
    localparam int VT = 68, VA = 56, VSS = 58, VSL = 8;
    localparam int FR = HT * VT;

    typedef struct packed {
        logic [8:0] h;
        logic [8:0] v;
        logic [9:0] cd;
        logic sh;
        logic nc;
        logic nh;
        logic nv;
        logic vbl;
    } obs_t;

    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
        logic vbl;
    } tim_t;

    logic V6M = 1'b0, NRESET = 1'b0, PRIOR = 1'b0, OBJ_SHD = 1'b0;
    logic [9:0] FIX_CD = '0, A_CD = '0, B_CD = '0, OBJ_CD = '0;
    logic [3:0] layer_mask = 4'h0;
    logic [8:0] HCNT, VCNT;
    logic NHSYNC, NVSYNC, VBL_IRQ, SHADOW, NCBLK;
    logic [9:0] CD;

    obs_t q[$];
    obs_t got, want, rst_v;
    tim_t pt;
    int mh, mv;
    int ncmp = 0, nerr = 0;

    tmnt_color_mixer #(
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_ST(VSS), .V_SYNC_LEN(VSL)
    ) dut (
        .V6M(V6M), .NRESET(NRESET), .PRIOR(PRIOR),
        .FIX_CD(FIX_CD), .A_CD(A_CD), .B_CD(B_CD), .OBJ_CD(OBJ_CD), .OBJ_SHD(OBJ_SHD),
`ifdef TMNT_LAYER_MASK_EN
        .LAYER_MASK(layer_mask),
`endif
        .HCNT(HCNT), .VCNT(VCNT), .NHSYNC(NHSYNC), .NVSYNC(NVSYNC), .VBL_IRQ(VBL_IRQ),
        .CD(CD), .SHADOW(SHADOW), .NCBLK(NCBLK)
    );

    always #5 V6M = ~V6M;

    function automatic obs_t sample();
        return {HCNT, VCNT, CD, SHADOW, NCBLK, NHSYNC, NVSYNC, VBL_IRQ};
    endfunction

    function automatic tim_t raw_t(input int h, input int v);
        tim_t t;
        t.vis = (h < HA) && (v < VA);
        t.hs = (h >= HSS) && (h < HSS + HSL);
        t.vs = (v >= VSS) && (v < VSS + VSL);
        t.vbl = (h == 0) && (v == VA);
        return t;
    endfunction

    // walks the priority list in order; returns {shadow, code}
    function automatic logic [10:0] ref_pix(input logic [9:0] f, a, b, o, input logic s, p, input logic [3:0] m);
        logic [9:0] l[4];
        int slot, win;
        if (m[0]) f = '0;
        if (m[1]) a = '0;
        if (m[2]) b = '0;
        if (m[3]) begin
            o = '0;
            s = 1'b0;
        end
        slot = p ? 2 : 1;
        l[0] = f;
        l[1] = p ? a : o;
        l[2] = p ? o : a;
        l[3] = b;
        win = 4;
        for (int i = 3; i >= 0; i--)
            if (l[i][3:0] != 4'h0 && !(i == slot && s)) win = i;
        return {(o[3:0] != 4'h0) && s && (win > slot), (win == 4) ? 10'h000 : l[win]};
    endfunction

    function automatic logic [9:0] rc();
        return ($urandom_range(3) == 0) ? {6'($urandom), 4'h0} : 10'($urandom);
    endfunction

    task automatic init_model();
        obs_t b;
        b = '0;
        b.nh = 1'b1;
        b.nv = 1'b1;
        q.delete();
        q.push_back(b);
        q.push_back(b);
        pt = '0;
        mh = 0;
        mv = 0;
    endtask

    // one pixel clock: capture this cycle's outputs and expectation, drive new inputs, queue their result
    task automatic tick(input logic [9:0] f, a, b, o, input logic s, p);
        obs_t e;
        logic [10:0] r;
        got = sample();
        want = q.pop_front();
        want.h = 9'(mh);
        want.v = 9'(mv);
        FIX_CD = f;
        A_CD = a;
        B_CD = b;
        OBJ_CD = o;
        OBJ_SHD = s;
        PRIOR = p;
        r = ref_pix(f, a, b, o, s, p, layer_mask);
        e = '0;
        e.cd = pt.vis ? r[9:0] : 10'h000;
        e.sh = pt.vis & r[10];
        e.nc = pt.vis;
        e.nh = ~pt.hs;
        e.nv = ~pt.vs;
        e.vbl = pt.vbl;
        q.push_back(e);
        pt = raw_t(mh, mv);
        mv = (mh == HT - 1) ? ((mv == VT - 1) ? 0 : mv + 1) : mv;
        mh = (mh == HT - 1) ? 0 : mh + 1;
        @(negedge V6M);
    endtask

    task automatic hold(input logic [9:0] f, a, b, o, input logic s, p);
        repeat (3) tick(f, a, b, o, s, p);
    endtask

    task automatic test_reset();
        NRESET = 1'b0;
        repeat (3) @(negedge V6M);
        got = sample();
        ncmp++;
        if (got !== rst_v) begin nerr++; $display("FAIL reset: got %h want %h", got, rst_v); end
        NRESET = 1'b1;
        init_model();
    endtask

    task automatic test_frame();
        int hs_low = 0, hs_fall = 0, hs_bad = 0, run = 0, vs_low = 0, vs_fall = 0, vbl_n = 0, nc_n = 0, blank_bad = 0;
        obs_t prv;
        prv = rst_v;
        for (int k = 0; k < FR + 4; k++) begin
            tick(rc(), rc(), rc(), rc(), 1'($urandom), 1'($urandom));
            ncmp++;
            if (got !== want) begin nerr++; $display("FAIL frame k=%0d: got %h want %h", k, got, want); end
            if (k == 2 || k == FR + 2) begin
                ncmp++;
                if (got.nc !== 1'b0) begin nerr++; $display("FAIL pix_latency_pre k=%0d: NCBLK %b want 0", k, got.nc); end
            end
            if (k == 3 || k == FR + 3) begin
                ncmp++;
                if (got.nc !== 1'b1) begin nerr++; $display("FAIL pix_latency k=%0d: NCBLK %b want 1", k, got.nc); end
            end
            if (k >= 3 && k < FR + 3) begin
                if (!got.nh) begin
                    hs_low++;
                    run++;
                    if (prv.nh) hs_fall++;
                end else if (!prv.nh) begin
                    if (run != HSL) hs_bad++;
                    run = 0;
                end
                if (!got.nv) begin
                    vs_low++;
                    if (prv.nv) vs_fall++;
                end
                vbl_n += int'(got.vbl);
                nc_n += int'(got.nc);
                if (!got.nc && (got.cd != 10'h000 || got.sh)) blank_bad++;
            end
            prv = got;
        end
        ncmp++;
        if (hs_low != VT * HSL || hs_fall != VT || hs_bad != 0) begin
            nerr++; $display("FAIL hsync: low %0d pulses %0d badwidth %0d want %0d %0d 0", hs_low, hs_fall, hs_bad, VT * HSL, VT);
        end
        ncmp++;
        if (vs_low != VSL * HT || vs_fall != 1) begin nerr++; $display("FAIL vsync: low %0d pulses %0d want %0d 1", vs_low, vs_fall, VSL * HT); end
        ncmp++;
        if (vbl_n != 1) begin nerr++; $display("FAIL vbl_count: got %0d want 1", vbl_n); end
        ncmp++;
        if (nc_n != HA * VA) begin nerr++; $display("FAIL visible_count: got %0d want %0d", nc_n, HA * VA); end
        ncmp++;
        if (blank_bad != 0) begin nerr++; $display("FAIL blank_clean: %0d blanked pixels carried colour/shadow", blank_bad); end
    endtask

    task automatic test_priority();
        hold(10'h015, 10'h101, 10'h302, 10'h203, 1'b0, 1'b0);
        ncmp++;
        if (got !== want || got.cd !== 10'h015) begin nerr++; $display("FAIL prio0_fix: got %h want %h cd 015", got, want); end
        hold(10'h010, 10'h101, 10'h302, 10'h203, 1'b0, 1'b0);
        ncmp++;
        if (got !== want || got.cd !== 10'h203) begin nerr++; $display("FAIL prio0_obj: got %h want %h cd 203", got, want); end
        hold(10'h000, 10'h101, 10'h302, 10'h203, 1'b0, 1'b1);
        ncmp++;
        if (got !== want || got.cd !== 10'h101) begin nerr++; $display("FAIL prio1_a: got %h want %h cd 101", got, want); end
        hold(10'h010, 10'h020, 10'h030, 10'h040, 1'b0, 1'b1);
        ncmp++;
        if (got !== want || got.cd !== 10'h000 || got.nc !== 1'b1) begin nerr++; $display("FAIL backdrop: got %h want %h cd 000", got, want); end
    endtask

    task automatic test_shadow();
        hold(10'h000, 10'h101, 10'h000, 10'h20F, 1'b1, 1'b0);
        ncmp++;
        if (got !== want || got.cd !== 10'h101 || got.sh !== 1'b1) begin nerr++; $display("FAIL shadow_a: got %h want %h cd 101 sh 1", got, want); end
        hold(10'h015, 10'h101, 10'h000, 10'h20F, 1'b1, 1'b0);
        ncmp++;
        if (got !== want || got.cd !== 10'h015 || got.sh !== 1'b0) begin nerr++; $display("FAIL shadow_fix: got %h want %h cd 015 sh 0", got, want); end
        hold(10'h000, 10'h101, 10'h302, 10'h20F, 1'b1, 1'b1);
        ncmp++;
        if (got !== want || got.cd !== 10'h101 || got.sh !== 1'b0) begin nerr++; $display("FAIL shadow_prio1_a: got %h want %h cd 101 sh 0", got, want); end
        hold(10'h000, 10'h000, 10'h302, 10'h20F, 1'b1, 1'b1);
        ncmp++;
        if (got !== want || got.cd !== 10'h302 || got.sh !== 1'b1) begin nerr++; $display("FAIL shadow_prio1_b: got %h want %h cd 302 sh 1", got, want); end
    endtask

    task automatic test_mid_reset();
        obs_t s;
        for (int k = 0; k < 30000 && !(mh == 100 && mv == 50); k++) begin
            tick(rc(), rc(), rc(), rc(), 1'($urandom), 1'($urandom));
            ncmp++;
            if (got !== want) begin nerr++; $display("FAIL run k=%0d: got %h want %h", k, got, want); end
        end
        s = sample();
        ncmp++;
        if (s.h !== 9'd100 || s.v !== 9'd50) begin nerr++; $display("FAIL mid_pos: got %0d,%0d want 100,50", s.h, s.v); end
        NRESET = 1'b0;
        #1;
        s = sample();
        ncmp++;
        if (s !== rst_v) begin nerr++; $display("FAIL reset_immediate: got %h want %h", s, rst_v); end
        repeat (3) @(negedge V6M);
        s = sample();
        ncmp++;
        if (s !== rst_v) begin nerr++; $display("FAIL reset_hold: got %h want %h", s, rst_v); end
        NRESET = 1'b1;
        init_model();
        for (int k = 0; k < 6; k++) begin
            tick(10'h015, 10'h101, 10'h302, 10'h203, 1'b0, 1'b0);
            ncmp++;
            if (got !== want) begin nerr++; $display("FAIL post_reset k=%0d: got %h want %h", k, got, want); end
            if (k == 2) begin
                ncmp++;
                if (got.nc !== 1'b0) begin nerr++; $display("FAIL post_reset_pre k=2: NCBLK %b want 0", got.nc); end
            end
            if (k == 3) begin
                ncmp++;
                if (got.nc !== 1'b1 || got.cd !== 10'h015) begin nerr++; $display("FAIL post_reset_first: NCBLK %b CD %h want 1 015", got.nc, got.cd); end
            end
        end
    endtask

`ifdef TMNT_LAYER_MASK_EN
    task automatic test_mask();
        layer_mask = 4'b0001;
        hold(10'h015, 10'h101, 10'h000, 10'h000, 1'b0, 1'b0);
        ncmp++;
        if (got !== want || got.cd !== 10'h101) begin nerr++; $display("FAIL mask_fix: got %h want %h cd 101", got, want); end
        layer_mask = 4'b1000;
        hold(10'h000, 10'h101, 10'h000, 10'h20F, 1'b1, 1'b0);
        ncmp++;
        if (got !== want || got.cd !== 10'h101 || got.sh !== 1'b0) begin nerr++; $display("FAIL mask_obj_shadow: got %h want %h sh 0", got, want); end
        layer_mask = 4'b0000;
    endtask
`endif

    initial begin
        rst_v = '0;
        rst_v.nh = 1'b1;
        rst_v.nv = 1'b1;
        test_reset();
        test_frame();
        test_priority();
        test_shadow();
        test_mid_reset();
`ifdef TMNT_LAYER_MASK_EN
        test_mask();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
